// File: rtl/controller_uart1_pkg.sv
// Shared definitions for the UART1 controller register slices: Avalon word
// addresses of the status input port and the edge-capture selector codes.
package controller_uart1_pkg;

  // Word addresses of the status input port
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  // Edge-capture selector values for the EDGE_TYPE parameter
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage : controller_uart1_pkg

// File: rtl/controller_uart1_status_debounce.sv
// One status bit: two-flop synchroniser followed by a counter-based debouncer.
// A change of the synchronised level is accepted only after DEBOUNCE_CYCLES
// consecutive samples differing from the current debounced level; any bounce
// back discards the partial count.
module controller_uart1_status_debounce #(
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter logic RESET_VAL       = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic deb
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // Two-stage synchroniser for the asynchronous input
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= RESET_VAL;
      s2 <= RESET_VAL;
    end else begin
      // NOTE: non-blocking assignments make s2 take the old s1, giving two real flop stages.
      s1 <= din;
      s2 <= s1;
    end
  end

  // Stability counter and debounced level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      deb <= RESET_VAL;
    end else if (s2 == deb) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      deb <= s2;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule : controller_uart1_status_debounce

// File: rtl/controller_uart1_status_input.sv
// Avalon-MM status input port for the UART1 subsystem.
// Synchronises and debounces WIDTH status lines, exposes the level at address 0,
// latches edges in a write-one-to-clear register at address 3 and raises a
// maskable level interrupt.
// Optional feature macro: CONTROLLER_UART1_STATUS_IRQ_EN
//   defined   -> irq_mask register at address 2, irq = |(edge_capture & irq_mask)
//   undefined -> no mask flops, address 2 reads 0, irq tied low
module controller_uart1_status_input
  import controller_uart1_pkg::*;
#(
  parameter int               WIDTH           = 3,
  parameter int               DEBOUNCE_CYCLES = 4,
  parameter int               EDGE_TYPE       = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] edges;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] wr_bits;
  logic             wr_en;
  logic             unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign wr_bits      = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    controller_uart1_status_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VAL       (RESET_VALUE[i])
    ) u_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (in_port[i]),
      .deb     (deb[i])
    );
  end

  // Previous debounced level; shares RESET_VALUE with deb so release is edge-free
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prev <= RESET_VALUE;
    else          prev <= deb;
  end

  // Edge qualification by configured direction
  always_comb begin
    // NOTE: default assignment first so every path drives edges and no latch is inferred.
    edges = '0;
    case (EDGE_TYPE)
      EDGE_RISE: edges = deb & ~prev;
      EDGE_FALL: edges = ~deb & prev;
      default:   edges = deb ^ prev;
    endcase
  end

  // Edge-capture register: W1C, a new edge wins over a simultaneous clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_capture <= '0;
    end else if (wr_en && address == ADDR_EDGE) begin
      edge_capture <= (edge_capture & ~wr_bits) | edges;
    end else begin
      edge_capture <= edge_capture | edges;
    end
  end

`ifdef CONTROLLER_UART1_STATUS_IRQ_EN
  // Interrupt mask register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask <= '0;
    end else if (wr_en && address == ADDR_MASK) begin
      irq_mask <= wr_bits;
    end
  end

  assign irq = |(edge_capture & irq_mask);
`else
  assign irq_mask = '0;
  assign irq      = 1'b0;
`endif

  // Zero-latency read mux, no side effects
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata[WIDTH-1:0] = deb;
      ADDR_MASK: readdata[WIDTH-1:0] = irq_mask;
      ADDR_EDGE: readdata[WIDTH-1:0] = edge_capture;
      default:   readdata = '0;
    endcase
  end

endmodule : controller_uart1_status_input

// File: tb/tb_controller_uart1_status_input.sv
// Self-checking bench for controller_uart1_status_input (WIDTH=3, DEBOUNCE_CYCLES=4,
// EDGE_TYPE=any, RESET_VALUE=0). Interrupt expectations follow whether
// CONTROLLER_UART1_STATUS_IRQ_EN is defined for the build.
module tb_controller_uart1_status_input;

`ifdef CONTROLLER_UART1_STATUS_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [2:0]  in_port = 3'b000;
  logic        irq;

  int checks = 0;
  int failures = 0;

  controller_uart1_status_input #(
    .WIDTH           (3),
    .DEBOUNCE_CYCLES (4),
    .EDGE_TYPE       (2),
    .RESET_VALUE     (3'b000)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          do_write;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    d = readdata;
  endtask

  vec_t        vecs[11];
  logic [31:0] rd;
  logic [31:0] m4;
  logic [31:0] m7;

  initial begin
    m4 = IRQ_EN ? 32'h4 : 32'h0;
    m7 = IRQ_EN ? 32'h7 : 32'h0;
    // state on entry: deb=101, edge_capture=101, mask=0
    vecs[0]  = '{1'b0, 2'd0, 32'h0,        32'h5, 1'b0};
    vecs[1]  = '{1'b0, 2'd1, 32'h0,        32'h0, 1'b0};
    vecs[2]  = '{1'b1, 2'd0, 32'hFFFF_FFFF, 32'h5, 1'b0};
    vecs[3]  = '{1'b1, 2'd1, 32'h7,        32'h0, 1'b0};
    vecs[4]  = '{1'b1, 2'd2, 32'h4,        m4,    IRQ_EN};
    vecs[5]  = '{1'b0, 2'd3, 32'h0,        32'h5, IRQ_EN};
    vecs[6]  = '{1'b1, 2'd3, 32'h0,        32'h5, IRQ_EN};
    vecs[7]  = '{1'b1, 2'd3, 32'h4,        32'h1, 1'b0};
    vecs[8]  = '{1'b1, 2'd2, 32'h7,        m7,    IRQ_EN};
    vecs[9]  = '{1'b1, 2'd2, 32'hFFFF_FFFC, m4,   1'b0};
    vecs[10] = '{1'b0, 2'd3, 32'h0,        32'h1, 1'b0};

    // 1. reset state
    #2;
    check("irq_in_reset", {31'b0, irq}, 32'h0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    bus_read(2'd0, rd); check("reset_data", rd, 32'h0);
    bus_read(2'd2, rd); check("reset_mask", rd, 32'h0);
    bus_read(2'd3, rd); check("reset_edge", rd, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);

    // 3. three-clock glitch on bit0 is rejected
    in_port = 3'b001;
    repeat (3) tick();
    in_port = 3'b000;
    for (int k = 0; k < 8; k++) begin
      tick();
      bus_read(2'd0, rd); check("glitch_data", rd, 32'h0);
    end
    bus_read(2'd3, rd); check("glitch_edge", rd, 32'h0);

    // 2. stable change 000->101: level visible exactly 6 clocks later, capture one clock after
    in_port = 3'b101;
    for (int k = 1; k <= 6; k++) begin
      tick();
      bus_read(2'd0, rd);
      check($sformatf("latency_data_clk%0d", k), rd, (k == 6) ? 32'h5 : 32'h0);
    end
    bus_read(2'd3, rd); check("edge_not_yet", rd, 32'h0);
    tick();
    bus_read(2'd3, rd); check("edge_captured", rd, 32'h5);

    // 4. register access table: ignored writes, mask, W1C
    for (int v = 0; v < 11; v++) begin
      if (vecs[v].do_write) bus_write(vecs[v].addr, vecs[v].wdata);
      bus_read(vecs[v].addr, rd);
      check($sformatf("vec%0d_rd", v), rd, vecs[v].exp_rd);
      check($sformatf("vec%0d_irq", v), {31'b0, irq}, {31'b0, vecs[v].exp_irq});
    end

    // 5. W1C of bit2 in the same clock as a new bit2 edge: set wins
    in_port = 3'b001;
    repeat (5) tick();
    bus_read(2'd0, rd); check("fall_data_pre", rd, 32'h5);
    tick();
    bus_read(2'd0, rd); check("fall_data_post", rd, 32'h1);
    bus_write(2'd3, 32'h4);
    bus_read(2'd3, rd); check("set_wins_edge", rd, 32'h5);
    check("set_wins_irq", {31'b0, irq}, {31'b0, IRQ_EN});
    bus_write(2'd3, 32'h4);
    bus_read(2'd3, rd); check("w1c_after_edge", rd, 32'h1);
    check("w1c_after_irq", {31'b0, irq}, 32'h0);

    // 6. reset mid-debounce with 2 counts accumulated on bit1
    in_port = 3'b011;
    repeat (4) tick();
    reset_n = 1'b0;
    #1;
    bus_read(2'd0, rd); check("midrst_data", rd, 32'h0);
    bus_read(2'd2, rd); check("midrst_mask", rd, 32'h0);
    bus_read(2'd3, rd); check("midrst_edge", rd, 32'h0);
    check("midrst_irq", {31'b0, irq}, 32'h0);
    in_port = 3'b000;
    tick();
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      bus_read(2'd3, rd); check("post_rst_edge", rd, 32'h0);
    end
    bus_read(2'd0, rd); check("post_rst_data", rd, 32'h0);
    check("post_rst_irq", {31'b0, irq}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_controller_uart1_status_input
